// File: rtl/dmem_responder.sv
// Data-memory responder: a word-organised RAM behind a valid/ready request channel and a
// valid/ready response channel, with a fixed number of wait states per access.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (one request outstanding at most)
//   req_addr          byte address; word index = req_addr[ADDR_W-1:2]
//   req_re            read request
//   req_wstrb         per-byte-lane write strobes
//   req_wdata         lane-aligned store data
//   rsp_valid/ready   response handshake
//   rsp_rdata         read word (0 for writes and errors)
//   rsp_err           request was illegal; no RAM access was made
//   busy              responder is not idle
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_re,
  input  logic [3:0]        req_wstrb,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned WordW    = ADDR_W - 2;
  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WordW-1:0]  word_q, word_d;
  logic              re_q, re_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IdxW-1:0]   mem_idx;
  logic              legal;
  logic              access_last;
  logic              unused_addr_lsb;

  // Byte offset within the word is irrelevant for a word-organised RAM.
  assign unused_addr_lsb = ^req_addr[1:0];

  assign mem_idx     = word_q[IdxW-1:0];
  assign legal       = (32'(word_q) < DEPTH_WORDS) &&
                       (re_q ? (wstrb_q == 4'h0) : (wstrb_q != 4'h0));
  assign access_last = (state_q == StAccess) && (cnt_q == WaitLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    re_d        = re_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          word_d  = req_addr[ADDR_W-1:2];
          re_d    = req_re;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          cnt_d   = 4'd0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == WaitLast) begin
          state_d     = StResp;
          rsp_err_d   = !legal;
          rsp_rdata_d = (legal && re_q) ? mem[mem_idx] : 32'h0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the next state so nothing depends on req_valid.
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      word_q      <= '0;
      re_q        <= 1'b0;
      wstrb_q     <= 4'h0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      re_q        <= re_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // RAM is never cleared; a reset during ACCESS suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && access_last && legal && !re_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts load/store requests over a valid/ready request channel and returns completion/read data over a valid/ready response channel.
- Owns a word-organised RAM with per-byte write strobes and a programmable number of wait states.
- Replaces the zero-latency data_mem so the core can be moved to a stall-capable memory interface.
- Returns raw 32-bit words; sign/zero extension stays in the core's data_ext.

Parameters:
- ADDR_W, 10, byte-address width (matches the core's alu_out[9:0] dmem address).
- DEPTH_WORDS, 256, number of 32-bit words implemented; legal range 1..2^(ADDR_W-2).
- WAIT_CYCLES, 2, extra access cycles per request; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2]; bits [1:0] are ignored.
- req_re  in  1  read request.
- req_wstrb  in  4  byte write strobes; bit i writes byte lane i (bits [8i+7:8i]).
- req_wdata  in  32  store data, lane-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read word; 0 for writes and errors.
- rsp_err  out  1  request was illegal and no memory access was performed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous; takes effect at any clk edge with rst=1.
  - State goes to IDLE, wait counter to 0.
  - Reset values: req_ready=1 on the first cycle after reset; rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - RAM contents are not cleared.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge E0, latch addr, re, wstrb and wdata, clear the counter, and go to ACCESS.
  - Request inputs are ignored outside IDLE.
- ACCESS:
  - req_ready=0. The counter increments each cycle.
  - At the edge where counter==WAIT_CYCLES (edge E0+WAIT_CYCLES+1), perform the operation, load the response registers, and go to RESP.
- Request legality:
  - Illegal if word index >= DEPTH_WORDS.
  - Illegal if re=1 and wstrb!=0.
  - Illegal if re=0 and wstrb==0.
  - An illegal request performs no RAM read or write and returns rsp_err=1, rsp_rdata=0.
  - An illegal request uses the same latency as a legal one.
- Legal read: rsp_rdata = RAM[word index], rsp_err=0.
- Legal write:
  - Only lanes with strobe=1 are updated; other lanes keep their old values.
  - rsp_rdata=0, rsp_err=0.
  - The write is committed at the ACCESS-exit edge, never earlier.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable while rsp_ready=0, with no limit on stall length.
  - On rsp_valid&&rsp_ready, go to IDLE and drop rsp_valid. req_ready=1 in the following cycle.
- Latency and throughput:
  - Accept edge to rsp_valid high: WAIT_CYCLES+1 cycles.
  - With rsp_ready tied high, the minimum spacing between accepted requests is WAIT_CYCLES+3 cycles.
- req_ready does not depend combinationally on req_valid.
- No outstanding requests beyond one; no reordering.
- Reset during ACCESS aborts the request: no RAM write occurs and no response is produced.
- Reset during RESP drops the response; the write has already been committed.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Simultaneous rst and any handshake: reset wins.

Test Plan:
- Reset, then write 0xDEADBEEF with wstrb=4'hF to addr 0x010, then read addr 0x010 (WAIT_CYCLES=2) -> rsp_valid rises exactly 3 cycles after each accept; read returns 0xDEADBEEF, rsp_err=0.
- Preload 0x11223344 at addr 0x020; write 0xAABBCCDD with wstrb=4'b0101; read addr 0x020 -> 0x11BB33DD.
- Read with rsp_ready held low for 7 cycles -> rsp_valid, rsp_rdata and rsp_err stay constant; req_ready=0 throughout; return to IDLE one cycle after rsp_ready=1.
- Illegal requests:
  - Addr 0x3FC with DEPTH_WORDS=64 -> rsp_err=1, rsp_rdata=0.
  - re=1 with wstrb=4'h1 -> rsp_err=1, rsp_rdata=0.
  - re=0 with wstrb=0 -> rsp_err=1, rsp_rdata=0.
  - Follow-up reads confirm the RAM is unchanged.
- Write 0x12345678 to addr 0x040 (old value 0xCAFEF00D), assert rst on the first ACCESS cycle -> no response; subsequent read returns 0xCAFEF00D. Outputs equal reset values the cycle after rst.
- Back-to-back requests with req_valid held high and rsp_ready tied high, WAIT_CYCLES=0 -> accepts every 3 cycles, responses in order; the second request is not accepted while busy=1.
